// File: rtl/flex_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : flex_updown_counter
// Description : Up/down counter with programmable terminal value, registered
//               terminal flag, one-cycle wrap pulse and saturating wrap tally.
//               Optional load port pair enabled by defining FLEX_CNT_LOAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module flex_updown_counter #(
    parameter int NUM_CNT_BITS = 4,
    parameter int WRAP_BITS    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic                    count_down,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
`ifdef FLEX_CNT_LOAD_EN
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
`endif
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    wrap_pulse,
    output logic [WRAP_BITS-1:0]    wrap_cnt
);

    localparam logic [NUM_CNT_BITS-1:0] c_one  = NUM_CNT_BITS'(1);
    localparam logic [NUM_CNT_BITS-1:0] c_zero = '0;

    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    r_flag;
    logic                    r_pulse;
    logic [WRAP_BITS-1:0]    r_wrap_cnt;

    logic [NUM_CNT_BITS-1:0] w_step_count;
    logic                    w_step_wrap;
    logic                    w_step_flag;
    logic                    w_wrap_sat;

    // Terminal for the direction in force at this edge; a zero terminal never flags.
    function automatic logic flag_of(input logic [NUM_CNT_BITS-1:0] val,
                                     input logic                    down,
                                     input logic [NUM_CNT_BITS-1:0] term);
        return (term != c_zero) && (down ? (val == c_one) : (val == term));
    endfunction

    always_comb begin
        w_step_count = r_count;
        w_step_wrap  = 1'b0;
        if (rollover_val == c_zero) begin
            w_step_count = c_zero;
        end else if (!count_down) begin
            if (r_count >= rollover_val) begin
                w_step_count = c_one;
                w_step_wrap  = 1'b1;
            end else begin
                w_step_count = r_count + c_one;
            end
        end else begin
            // From 0 the first down step just loads the terminal, not a wrap.
            if (r_count <= c_one) begin
                w_step_count = rollover_val;
                w_step_wrap  = (r_count == c_one);
            end else begin
                w_step_count = r_count - c_one;
            end
        end
        w_step_flag = flag_of(w_step_count, count_down, rollover_val);
        w_wrap_sat  = &r_wrap_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= c_zero;
            r_flag     <= 1'b0;
            r_pulse    <= 1'b0;
            r_wrap_cnt <= '0;
        end else if (clear) begin
            r_count <= c_zero;
            r_flag  <= 1'b0;
            r_pulse <= 1'b0;
`ifdef FLEX_CNT_LOAD_EN
        end else if (load) begin
            r_count <= load_val;
            r_flag  <= flag_of(load_val, count_down, rollover_val);
            r_pulse <= 1'b0;
`endif
        end else if (count_enable) begin
            r_count <= w_step_count;
            r_flag  <= w_step_flag;
            r_pulse <= w_step_wrap;
            if (w_step_wrap && !w_wrap_sat) begin
                r_wrap_cnt <= r_wrap_cnt + WRAP_BITS'(1);
            end
        end else begin
            r_pulse <= 1'b0;
        end
    end

    assign count_out     = r_count;
    assign rollover_flag = r_flag;
    assign wrap_pulse    = r_pulse;
    assign wrap_cnt      = r_wrap_cnt;

endmodule
`default_nettype wire

// File: tb/tb_flex_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_flex_updown_counter
// Description : Scoreboard bench for flex_updown_counter (8-bit and 2-bit tally
//               instances share stimulus); load scenario when FLEX_CNT_LOAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flex_updown_counter;

    typedef struct packed {
        logic [3:0] cnt;
        logic       flag;
        logic       pulse;
        logic [7:0] wc;
        logic [1:0] wc2;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       count_enable = 1'b0;
    logic       count_down = 1'b0;
    logic [3:0] rollover_val = 4'd0;
`ifdef FLEX_CNT_LOAD_EN
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
`endif
    logic [3:0] count_out, count_out2;
    logic       rollover_flag, rollover_flag2;
    logic       wrap_pulse, wrap_pulse2;
    logic [7:0] wrap_cnt;
    logic [1:0] wrap_cnt2;

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t sb[$];
    obs_t got, exp;

    // reference model state
    logic [3:0] m_cnt;
    logic       m_flag, m_pulse;
    logic [7:0] m_wc;
    logic [1:0] m_wc2;

    always #5 clk = ~clk;

    flex_updown_counter #(.NUM_CNT_BITS(4), .WRAP_BITS(8)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .count_enable(count_enable),
        .count_down(count_down), .rollover_val(rollover_val),
`ifdef FLEX_CNT_LOAD_EN
        .load(load), .load_val(load_val),
`endif
        .count_out(count_out), .rollover_flag(rollover_flag),
        .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt)
    );

    flex_updown_counter #(.NUM_CNT_BITS(4), .WRAP_BITS(2)) u_sat (
        .clk(clk), .rst(rst), .clear(clear), .count_enable(count_enable),
        .count_down(count_down), .rollover_val(rollover_val),
`ifdef FLEX_CNT_LOAD_EN
        .load(load), .load_val(load_val),
`endif
        .count_out(count_out2), .rollover_flag(rollover_flag2),
        .wrap_pulse(wrap_pulse2), .wrap_cnt(wrap_cnt2)
    );

    // Apply one edge's inputs and push the model's prediction for after that edge.
    task automatic drive(input logic r, input logic c, input logic en, input logic dn,
                         input logic [3:0] rv, input logic ld, input logic [3:0] lv);
        obs_t e;
        @(negedge clk);
        rst = r; clear = c; count_enable = en; count_down = dn; rollover_val = rv;
`ifdef FLEX_CNT_LOAD_EN
        load = ld; load_val = lv;
`endif
        if (r) begin
            m_cnt = 0; m_flag = 0; m_pulse = 0; m_wc = 0; m_wc2 = 0;
        end else if (c) begin
            m_cnt = 0; m_flag = 0; m_pulse = 0;
        end else if (ld) begin
            m_cnt = lv; m_pulse = 0;
            m_flag = (rv != 0) && (dn ? (lv == 1) : (lv == rv));
        end else if (en) begin
            m_pulse = 0;
            if (rv == 0) m_cnt = 0;
            else if (!dn) begin
                if (m_cnt >= rv) begin m_cnt = 1; m_pulse = 1; end
                else m_cnt = m_cnt + 4'd1;
            end else begin
                if (m_cnt == 1) begin m_cnt = rv; m_pulse = 1; end
                else if (m_cnt == 0) m_cnt = rv;
                else m_cnt = m_cnt - 4'd1;
            end
            m_flag = (rv != 0) && (dn ? (m_cnt == 1) : (m_cnt == rv));
            if (m_pulse) begin
                if (m_wc != 8'hFF) m_wc = m_wc + 8'd1;
                if (m_wc2 != 2'd3) m_wc2 = m_wc2 + 2'd1;
            end
        end else begin
            m_pulse = 0;
        end
        e.cnt = m_cnt; e.flag = m_flag; e.pulse = m_pulse; e.wc = m_wc; e.wc2 = m_wc2;
        sb.push_back(e);
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
        got.cnt = count_out; got.flag = rollover_flag; got.pulse = wrap_pulse;
        got.wc = wrap_cnt; got.wc2 = wrap_cnt2;
        exp = sb.pop_front();
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 4'd5, 0, 0); sample();
        drive(1, 0, 0, 0, 4'd5, 0, 0); sample();
        drive(0, 0, 0, 0, 4'd5, 0, 0); sample();
        n_checks++;
        if (got !== exp || got !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset: got=%h expected=%h", got, exp);
        end
    endtask

    task automatic test_count_up();
        logic [3:0] tbl [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1, 0, 4'd5, 0, 0); sample();
            n_checks++;
            if (got !== exp || got.cnt !== tbl[i] || got.flag !== (tbl[i] == 4'd5)
                || got.pulse !== (i == 5)) begin
                n_fail++;
                $display("FAIL count_up[%0d]: got=%h expected=%h table_cnt=%0d", i, got, exp, tbl[i]);
            end
        end
        n_checks++;
        if (wrap_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL count_up_tally: got=%0d expected=1", wrap_cnt);
        end
    endtask

    task automatic test_count_down();
        logic [3:0] tbl [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd4};
        drive(1, 0, 0, 1, 4'd4, 0, 0); sample();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 1, 4'd4, 0, 0); sample();
            n_checks++;
            if (got !== exp || got.cnt !== tbl[i] || got.flag !== (tbl[i] == 4'd1)
                || got.pulse !== (i == 4) || got.wc !== 8'(i == 4)) begin
                n_fail++;
                $display("FAIL count_down[%0d]: got=%h expected=%h table_cnt=%0d", i, got, exp, tbl[i]);
            end
        end
    endtask

    task automatic test_lower_rollover();
        drive(1, 0, 0, 0, 4'd10, 0, 0); sample();
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 1, 0, 4'd10, 0, 0); sample();
        end
        n_checks++;
        if (got !== exp || got.cnt !== 4'd9) begin
            n_fail++;
            $display("FAIL lower_rv_setup: got=%h expected=%h", got, exp);
        end
        drive(0, 0, 1, 0, 4'd6, 0, 0); sample();
        n_checks++;
        if (got !== exp || got.cnt !== 4'd1 || got.pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL lower_rv_wrap: got=%h expected=%h", got, exp);
        end
        drive(0, 1, 1, 0, 4'd6, 0, 0); sample();
        n_checks++;
        if (got !== exp || got.cnt !== 4'd0 || got.pulse !== 1'b0 || got.wc !== 8'd1) begin
            n_fail++;
            $display("FAIL clear_beats_enable: got=%h expected=%h", got, exp);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] tbl [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        drive(1, 0, 0, 0, 4'd1, 0, 0); sample();
        drive(0, 0, 1, 0, 4'd1, 0, 0); sample();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1, 0, 4'd1, 0, 0); sample();
            n_checks++;
            if (got !== exp || got.wc2 !== tbl[i] || got.pulse !== 1'b1 || got.cnt !== 4'd1) begin
                n_fail++;
                $display("FAIL saturate[%0d]: got=%h expected=%h table_tally=%0d", i, got, exp, tbl[i]);
            end
        end
        drive(0, 0, 1, 0, 4'd0, 0, 0); sample();
        n_checks++;
        if (got !== exp || got.cnt !== 4'd0 || got.flag !== 1'b0 || got.pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_rollover: got=%h expected=%h", got, exp);
        end
    endtask

`ifdef FLEX_CNT_LOAD_EN
    task automatic test_load();
        drive(0, 0, 1, 0, 4'd8, 1, 4'd12); sample();
        n_checks++;
        if (got !== exp || got.cnt !== 4'd12 || got.pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL load: got=%h expected=%h", got, exp);
        end
        drive(0, 0, 1, 0, 4'd8, 0, 4'd0); sample();
        n_checks++;
        if (got !== exp || got.cnt !== 4'd1 || got.pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL load_wrap: got=%h expected=%h", got, exp);
        end
        drive(1, 0, 1, 0, 4'd8, 1, 4'd3); sample();
        n_checks++;
        if (got !== exp || got !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL load_rst: got=%h expected=%h", got, exp);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [3:0] lv;
        logic       ld;
        for (int i = 0; i < 80; i++) begin
            lv = 4'($urandom_range(0, 15));
`ifdef FLEX_CNT_LOAD_EN
            ld = ($urandom_range(0, 9) == 0);
`else
            ld = 1'b0;
`endif
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 7)), ld, lv);
            sample();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got=%h expected=%h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_lower_rollover();
        test_saturate();
`ifdef FLEX_CNT_LOAD_EN
        test_load();
`endif
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
